// File: rtl/ls_issue_queue.sv
// ls_issue_queue: in-order load/store issue queue with address generation.
//
// Holds up to DEPTH memory ops from dispatch in a circular buffer, captures missing
// operands (base, store data) from the three writeback buses, and issues the head entry
// only, in strict program order, once its operands are ready. The issued op is
// registered into the data-memory input register with Addr = base + imm.
//
// Optional feature (macro LSQ_WB_BYPASS_EN): when defined, the head's readiness check
// also looks at the current writeback buses, so the head may issue in the same cycle
// its missing operand is broadcast, with the bus data forwarded into Addr/busX.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   flush                    clears queue and output register; same-cycle dispatch ignored
//   freeze_back              holds the output register and blocks issue
//   full_FIFO                downstream store FIFO full; blocks store issue
//   valid_dp .. imm_dp       dispatch interface (one op per cycle)
//   full_lsq                 queue full; dispatch must not assert valid_dp
//   valid_wb, Pw_wb, Result_wb   three writeback buses (bus k at [5k+4:5k] / [16k+15:16k])
//   valid_ls, mode, busX, Addr, tag_ROB_ls, Px   registered issued op
module ls_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze_back,
    input  logic        full_FIFO,
    input  logic        valid_dp,
    input  logic        mode_dp,
    input  logic [4:0]  tag_ROB_dp,
    input  logic [4:0]  Pw_dp,
    input  logic [4:0]  Pa_dp,
    input  logic        ready_a_dp,
    input  logic [15:0] data_a_dp,
    input  logic [4:0]  Px_dp,
    input  logic        ready_x_dp,
    input  logic [15:0] data_x_dp,
    input  logic [15:0] imm_dp,
    output logic        full_lsq,
    input  logic [2:0]  valid_wb,
    input  logic [14:0] Pw_wb,
    input  logic [47:0] Result_wb,
    output logic        valid_ls,
    output logic        mode,
    output logic [15:0] busX,
    output logic [15:0] Addr,
    output logic [4:0]  tag_ROB_ls,
    output logic [4:0]  Px
);

    localparam int unsigned CntW = PTR_W + 1;

    // Writeback lookup: {hit, data}; the lowest-index matching bus wins.
    function automatic logic [16:0] wb_lookup(input logic [4:0] p);
        logic [16:0] r;
        r = '0;
        for (int k = 2; k >= 0; k--) begin
            if (valid_wb[k] && (Pw_wb[5*k +: 5] == p)) r = {1'b1, Result_wb[16*k +: 16]};
        end
        return r;
    endfunction

    // Queue storage
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] mode_q;
    logic [DEPTH-1:0] rdy_a_q;
    logic [DEPTH-1:0] rdy_x_q;
    logic [4:0]       tag_q  [DEPTH];
    logic [4:0]       pw_q   [DEPTH];
    logic [4:0]       pa_q   [DEPTH];
    logic [4:0]       px_q   [DEPTH];
    logic [15:0]      da_q   [DEPTH];
    logic [15:0]      dx_q   [DEPTH];
    logic [15:0]      imm_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Output register
    logic        vld_out_q, vld_out_d;
    logic        mode_out_q, mode_out_d;
    logic [15:0] busx_q, busx_d;
    logic [15:0] addr_q, addr_d;
    logic [4:0]  tag_out_q, tag_out_d;
    logic [4:0]  px_out_q, px_out_d;

    logic [16:0] hit_a [DEPTH];
    logic [16:0] hit_x [DEPTH];
    logic [16:0] cap_a, cap_x;
    logic        new_rdy_a, new_rdy_x;
    logic [15:0] new_da, new_dx;

    logic        dispatch, issue, eligible;
    logic        h_vld, h_store, h_rdy_a, h_rdy_x, store_busy;
    logic [15:0] h_base, h_data;

    assign full_lsq = (cnt_q == CntW'(DEPTH));
    assign dispatch = valid_dp && !full_lsq && !flush;

    // Per-entry wakeup matches and dispatch-time operand capture
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_a[i] = wb_lookup(pa_q[i]);
            hit_x[i] = wb_lookup(px_q[i]);
        end
        cap_a     = wb_lookup(Pa_dp);
        cap_x     = wb_lookup(Px_dp);
        new_rdy_a = ready_a_dp || cap_a[16];
        new_da    = ready_a_dp ? data_a_dp : cap_a[15:0];
        // A load has no store-data operand, so it is marked ready and never waits on it.
        new_rdy_x = mode_dp || ready_x_dp || cap_x[16];
        new_dx    = ready_x_dp ? data_x_dp : cap_x[15:0];
    end

    // Head readiness, optionally forwarding from the current writeback buses
    always_comb begin
        h_vld   = vld_q[head_q];
        h_store = !mode_q[head_q];
`ifdef LSQ_WB_BYPASS_EN
        h_rdy_a = rdy_a_q[head_q] || hit_a[head_q][16];
        h_rdy_x = rdy_x_q[head_q] || hit_x[head_q][16];
        h_base  = rdy_a_q[head_q] ? da_q[head_q] : hit_a[head_q][15:0];
        h_data  = rdy_x_q[head_q] ? dx_q[head_q] : hit_x[head_q][15:0];
`else
        h_rdy_a = rdy_a_q[head_q];
        h_rdy_x = rdy_x_q[head_q];
        h_base  = da_q[head_q];
        h_data  = dx_q[head_q];
`endif
        // At most one store every other cycle: block while the output holds a store.
        store_busy = vld_out_q && !mode_out_q;
        eligible   = h_vld && h_rdy_a &&
                     (!h_store || (h_rdy_x && !full_FIFO && !store_busy));
        issue      = eligible && !freeze_back && !flush;
    end

    // Pointers, count and output register next state
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        vld_out_d  = vld_out_q;
        mode_out_d = mode_out_q;
        busx_d     = busx_q;
        addr_d     = addr_q;
        tag_out_d  = tag_out_q;
        px_out_d   = px_out_q;

        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
            vld_out_d  = 1'b0;
            mode_out_d = 1'b0;
            busx_d     = '0;
            addr_d     = '0;
            tag_out_d  = '0;
            px_out_d   = '0;
        end else begin
            if (issue)    head_d = head_q + PTR_W'(1);
            if (dispatch) tail_d = tail_q + PTR_W'(1);
            if (dispatch && !issue)      cnt_d = cnt_q + CntW'(1);
            else if (!dispatch && issue) cnt_d = cnt_q - CntW'(1);

            if (!freeze_back) begin
                if (issue) begin
                    vld_out_d  = 1'b1;
                    mode_out_d = !h_store;
                    tag_out_d  = tag_q[head_q];
                    addr_d     = h_base + imm_q[head_q];
                    busx_d     = h_store ? h_data : 16'h0000;
                    px_out_d   = h_store ? 5'd0 : pw_q[head_q];
                end else begin
                    vld_out_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            vld_out_q  <= 1'b0;
            mode_out_q <= 1'b0;
            busx_q     <= '0;
            addr_q     <= '0;
            tag_out_q  <= '0;
            px_out_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            vld_out_q  <= vld_out_d;
            mode_out_q <= mode_out_d;
            busx_q     <= busx_d;
            addr_q     <= addr_d;
            tag_out_q  <= tag_out_d;
            px_out_q   <= px_out_d;
        end
    end

    // Entry valid bits; the issued slot and the dispatch slot never coincide
    // (that would need a full queue, where dispatch is refused).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            if (issue)    vld_q[head_q] <= 1'b0;
            if (dispatch) vld_q[tail_q] <= 1'b1;
        end
    end

    // Entry payload: meaningful only while the entry is valid, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !flush) begin
                if (!rdy_a_q[i] && hit_a[i][16]) begin
                    rdy_a_q[i] <= 1'b1;
                    da_q[i]    <= hit_a[i][15:0];
                end
                if (!rdy_x_q[i] && hit_x[i][16]) begin
                    rdy_x_q[i] <= 1'b1;
                    dx_q[i]    <= hit_x[i][15:0];
                end
            end
        end
        if (dispatch) begin
            mode_q[tail_q]  <= mode_dp;
            tag_q[tail_q]   <= tag_ROB_dp;
            pw_q[tail_q]    <= Pw_dp;
            pa_q[tail_q]    <= Pa_dp;
            px_q[tail_q]    <= Px_dp;
            imm_q[tail_q]   <= imm_dp;
            rdy_a_q[tail_q] <= new_rdy_a;
            da_q[tail_q]    <= new_da;
            rdy_x_q[tail_q] <= new_rdy_x;
            dx_q[tail_q]    <= new_dx;
        end
    end

    assign valid_ls   = vld_out_q;
    assign mode       = mode_out_q;
    assign busX       = busx_q;
    assign Addr       = addr_q;
    assign tag_ROB_ls = tag_out_q;
    assign Px         = px_out_q;

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed testbench for ls_issue_queue. Inputs are driven and outputs sampled 1 ns
// after each rising edge. Expected values are hand-computed constants.
module tb_ls_issue_queue;

`ifdef LSQ_WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush, freeze_back, full_FIFO;
    logic        valid_dp, mode_dp, ready_a_dp, ready_x_dp;
    logic [4:0]  tag_ROB_dp, Pw_dp, Pa_dp, Px_dp;
    logic [15:0] data_a_dp, data_x_dp, imm_dp;
    logic        full_lsq;
    logic [2:0]  valid_wb;
    logic [14:0] Pw_wb;
    logic [47:0] Result_wb;
    logic        valid_ls, mode;
    logic [15:0] busX, Addr;
    logic [4:0]  tag_ROB_ls, Px;

    int errs   = 0;
    int checks = 0;

    ls_issue_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
        .full_FIFO(full_FIFO), .valid_dp(valid_dp), .mode_dp(mode_dp),
        .tag_ROB_dp(tag_ROB_dp), .Pw_dp(Pw_dp), .Pa_dp(Pa_dp), .ready_a_dp(ready_a_dp),
        .data_a_dp(data_a_dp), .Px_dp(Px_dp), .ready_x_dp(ready_x_dp),
        .data_x_dp(data_x_dp), .imm_dp(imm_dp), .full_lsq(full_lsq),
        .valid_wb(valid_wb), .Pw_wb(Pw_wb), .Result_wb(Result_wb),
        .valid_ls(valid_ls), .mode(mode), .busX(busX), .Addr(Addr),
        .tag_ROB_ls(tag_ROB_ls), .Px(Px)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string s, input logic v, input logic m, input logic [15:0] a,
                           input logic [15:0] bx, input logic [4:0] t, input logic [4:0] p);
        check({s, ".valid"}, 32'(valid_ls), 32'(v));
        check({s, ".mode"},  32'(mode), 32'(m));
        check({s, ".addr"},  32'(Addr), 32'(a));
        check({s, ".busx"},  32'(busX), 32'(bx));
        check({s, ".tag"},   32'(tag_ROB_ls), 32'(t));
        check({s, ".px"},    32'(Px), 32'(p));
    endtask

    task automatic set_dp(input logic m, input logic [4:0] t, input logic [4:0] pw,
                          input logic [4:0] pa, input logic ra, input logic [15:0] da,
                          input logic [4:0] px, input logic rx, input logic [15:0] dx,
                          input logic [15:0] imm);
        valid_dp = 1'b1; mode_dp = m; tag_ROB_dp = t; Pw_dp = pw; Pa_dp = pa;
        ready_a_dp = ra; data_a_dp = da; Px_dp = px; ready_x_dp = rx; data_x_dp = dx;
        imm_dp = imm;
    endtask

    task automatic disp(input logic m, input logic [4:0] t, input logic [4:0] pw,
                        input logic [4:0] pa, input logic ra, input logic [15:0] da,
                        input logic [4:0] px, input logic rx, input logic [15:0] dx,
                        input logic [15:0] imm);
        set_dp(m, t, pw, pa, ra, da, px, rx, dx, imm);
        step();
        valid_dp = 1'b0;
    endtask

    task automatic wb(input int k, input logic [4:0] p, input logic [15:0] d);
        valid_wb[k] = 1'b1;
        Pw_wb[5*k +: 5] = p;
        Result_wb[16*k +: 16] = d;
    endtask

    initial begin
        int exp_t;
        flush = 0; freeze_back = 0; full_FIFO = 0;
        valid_dp = 0; mode_dp = 0; tag_ROB_dp = 0; Pw_dp = 0; Pa_dp = 0; ready_a_dp = 0;
        data_a_dp = 0; Px_dp = 0; ready_x_dp = 0; data_x_dp = 0; imm_dp = 0;
        valid_wb = 0; Pw_wb = 0; Result_wb = 0;

        // Reset state
        step();
        step();
        chk_out("rst", 1'b0, 1'b0, 16'h0, 16'h0, 5'd0, 5'd0);
        check("rst.full", 32'(full_lsq), 32'd0);
        rst = 1'b1;
        step();

        // Ready load: issues one edge after dispatch
        disp(1'b1, 5'd3, 5'd7, 5'd0, 1'b1, 16'h0010, 5'd0, 1'b0, 16'h0, 16'h0004);
        check("t1.lat", 32'(valid_ls), 32'd0);
        step();
        chk_out("t1", 1'b1, 1'b1, 16'h0014, 16'h0, 5'd3, 5'd7);
        step();
        check("t1.drop", 32'(valid_ls), 32'd0);
        check("t1.hold", 32'(Addr), 32'h0014);

        // Store with base pending on P9, woken by bus 2
        disp(1'b0, 5'd4, 5'd0, 5'd9, 1'b0, 16'h0, 5'd1, 1'b1, 16'hBEEF, 16'h0010);
        wb(2, 5'd9, 16'h00F0);
        step();
        valid_wb = 0;
        if (!Bypass) begin
            check("t2.lat", 32'(valid_ls), 32'd0);
            step();
        end
        chk_out("t2", 1'b1, 1'b0, 16'h0100, 16'hBEEF, 5'd4, 5'd0);
        step();

        // Base captured at dispatch from a same-cycle broadcast
        set_dp(1'b1, 5'd5, 5'd12, 5'd6, 1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 16'h0002);
        wb(1, 5'd6, 16'h0300);
        step();
        valid_dp = 0; valid_wb = 0;
        check("cap.lat", 32'(valid_ls), 32'd0);
        step();
        chk_out("cap", 1'b1, 1'b1, 16'h0302, 16'h0, 5'd5, 5'd12);
        step();

        // Several buses match: lowest index wins
        disp(1'b1, 5'd6, 5'd13, 5'd5, 1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 16'h0001);
        wb(0, 5'd5, 16'h0100);
        wb(1, 5'd5, 16'h0200);
        wb(2, 5'd5, 16'h0400);
        step();
        valid_wb = 0;
        if (!Bypass) step();
        chk_out("prio", 1'b1, 1'b1, 16'h0101, 16'h0, 5'd6, 5'd13);
        step();

        // Fill with the head blocked, refuse a 9th op, then drain in order (pointers wrap)
        for (int i = 0; i < 8; i++) begin
            disp(1'b1, 5'(i), 5'(i), (i == 0) ? 5'd20 : 5'd0, (i != 0), 16'(i * 16),
                 5'd0, 1'b0, 16'h0, 16'h0);
        end
        check("t3.full", 32'(full_lsq), 32'd1);
        set_dp(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 16'h0080, 5'd0, 1'b0, 16'h0, 16'h0);
        step();
        check("t3.full2", 32'(full_lsq), 32'd1);
        check("t3.blocked", 32'(valid_ls), 32'd0);
        wb(0, 5'd20, 16'h0000);
        step();
        valid_dp = 0; valid_wb = 0;
        exp_t = 0;
        for (int c = 0; c < 12; c++) begin
            if (valid_ls) begin
                check("t3.tag", 32'(tag_ROB_ls), 32'(exp_t));
                check("t3.addr", 32'(Addr), 32'(exp_t * 16));
                exp_t++;
            end
            step();
        end
        check("t3.count", 32'(exp_t), 32'd8);
        check("t3.empty", 32'(full_lsq), 32'd0);

        // Back-to-back ready stores issue on alternate cycles
        disp(1'b0, 5'd10, 5'd0, 5'd0, 1'b1, 16'h1000, 5'd0, 1'b1, 16'h1111, 16'h0001);
        disp(1'b0, 5'd11, 5'd0, 5'd0, 1'b1, 16'h2000, 5'd0, 1'b1, 16'h2222, 16'h0002);
        chk_out("t4a", 1'b1, 1'b0, 16'h1001, 16'h1111, 5'd10, 5'd0);
        step();
        check("t4.gap", 32'(valid_ls), 32'd0);
        step();
        chk_out("t4b", 1'b1, 1'b0, 16'h2002, 16'h2222, 5'd11, 5'd0);
        step();

        // full_FIFO holds a ready store back until it deasserts
        full_FIFO = 1;
        disp(1'b0, 5'd12, 5'd0, 5'd0, 1'b1, 16'h3000, 5'd0, 1'b1, 16'h3333, 16'h0003);
        check("t4.ff0", 32'(valid_ls), 32'd0);
        step();
        check("t4.ff1", 32'(valid_ls), 32'd0);
        step();
        check("t4.ff2", 32'(valid_ls), 32'd0);
        full_FIFO = 0;
        step();
        chk_out("t4c", 1'b1, 1'b0, 16'h3003, 16'h3333, 5'd12, 5'd0);

        // freeze_back for 3 edges: outputs hold, no issue; head issues after release
        freeze_back = 1;
        disp(1'b1, 5'd13, 5'd14, 5'd0, 1'b1, 16'h4000, 5'd0, 1'b0, 16'h0, 16'h0010);
        chk_out("t5.h1", 1'b1, 1'b0, 16'h3003, 16'h3333, 5'd12, 5'd0);
        step();
        chk_out("t5.h2", 1'b1, 1'b0, 16'h3003, 16'h3333, 5'd12, 5'd0);
        step();
        chk_out("t5.h3", 1'b1, 1'b0, 16'h3003, 16'h3333, 5'd12, 5'd0);
        freeze_back = 0;
        step();
        chk_out("t5.go", 1'b1, 1'b1, 16'h4010, 16'h0, 5'd13, 5'd14);

        // Flush with 5 blocked entries and a valid (frozen) output
        freeze_back = 1;
        for (int i = 0; i < 5; i++) begin
            disp(1'b1, 5'(15 + i), 5'd1, 5'd21, 1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 16'h0);
        end
        check("t6.hold", 32'(tag_ROB_ls), 32'd13);
        flush = 1;
        set_dp(1'b1, 5'd22, 5'd2, 5'd0, 1'b1, 16'h5000, 5'd0, 1'b0, 16'h0, 16'h0);
        wb(0, 5'd21, 16'h0055);
        step();
        flush = 0; freeze_back = 0; valid_dp = 0; valid_wb = 0;
        chk_out("t6.fl", 1'b0, 1'b0, 16'h0, 16'h0, 5'd0, 5'd0);
        check("t6.full", 32'(full_lsq), 32'd0);
        step();
        check("t6.nodp", 32'(valid_ls), 32'd0);
        wb(0, 5'd21, 16'h0066);
        step();
        valid_wb = 0;
        check("t6.nowk", 32'(valid_ls), 32'd0);
        step();
        check("t6.nowk2", 32'(valid_ls), 32'd0);
        disp(1'b1, 5'd20, 5'd3, 5'd0, 1'b1, 16'h6000, 5'd0, 1'b0, 16'h0, 16'h0006);
        step();
        chk_out("t6.new", 1'b1, 1'b1, 16'h6006, 16'h0, 5'd20, 5'd3);

        // Asynchronous reset mid-operation
        disp(1'b1, 5'd9, 5'd4, 5'd22, 1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 16'h0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("t7.rst", 1'b0, 1'b0, 16'h0, 16'h0, 5'd0, 5'd0);
        check("t7.full", 32'(full_lsq), 32'd0);
        rst = 1'b1;
        step();
        wb(0, 5'd22, 16'h0077);
        step();
        valid_wb = 0;
        step();
        check("t7.gone", 32'(valid_ls), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
